// File: rtl/mult_acc_stream.sv
// Multi-lane streaming multiply-accumulate with per-beat signed mode and first/last framing.
// Latency: a last beat accepted in cycle c shows out_valid in cycle c+PIPELINE+1 (PIPELINE mult stages + acc).
// Backpressure: out_valid && !out_ready freezes every stage; in_ready = !that. MULT_ACC_SAT_EN enables saturation.
`timescale 1ns/1ps
module mult_acc_stream #(
    parameter int WIDTHA   = 16,
    parameter int WIDTHB   = 16,
    parameter int WIDTHP   = WIDTHA + WIDTHB,
    parameter int ACCW     = WIDTHP + 8,
    parameter int LANES    = 1,
    parameter int PIPELINE = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*WIDTHA-1:0] in_a,
    input  logic [LANES*WIDTHB-1:0] in_b,
    input  logic                    in_signed,
    input  logic                    in_first,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ACCW-1:0]   out_acc,
    output logic [LANES-1:0]        out_sat
);

    localparam int IS  = PIPELINE >> 1;
    localparam int OS  = PIPELINE - IS;
    localparam int PFW = WIDTHA + WIDTHB + 2;

    typedef struct packed {
        logic vld;
        logic sgn;
        logic first;
        logic last;
    } side_t;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } ctl_t;

    logic                    stall;
    side_t                   in_sb;
    side_t                   mul_sb;
    logic [LANES*WIDTHA-1:0] mul_a;
    logic [LANES*WIDTHB-1:0] mul_b;
    logic [LANES*ACCW-1:0]   prod_ext;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign in_sb    = '{vld: in_valid, sgn: in_signed, first: in_first, last: in_last};

    // Operand-side register stages (may be zero for PIPELINE=1)
    generate
        if (IS > 0) begin : g_in_regs
            logic [LANES*WIDTHA-1:0] a_q  [IS];
            logic [LANES*WIDTHB-1:0] b_q  [IS];
            side_t                   sb_q [IS];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < IS; i++) begin
                        a_q[i]  <= '0;
                        b_q[i]  <= '0;
                        sb_q[i] <= '0;
                    end
                end else if (!stall) begin
                    a_q[0]  <= in_a;
                    b_q[0]  <= in_b;
                    sb_q[0] <= in_sb;
                    for (int i = 1; i < IS; i++) begin
                        a_q[i]  <= a_q[i-1];
                        b_q[i]  <= b_q[i-1];
                        sb_q[i] <= sb_q[i-1];
                    end
                end
            end

            assign mul_a  = a_q[IS-1];
            assign mul_b  = b_q[IS-1];
            assign mul_sb = sb_q[IS-1];
        end else begin : g_in_direct
            assign mul_a  = in_a;
            assign mul_b  = in_b;
            assign mul_sb = in_sb;
        end
    endgenerate

    // One extra operand bit lets a single signed multiplier serve both modes
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_mul
            logic signed [WIDTHA:0] ax;
            logic signed [WIDTHB:0] bx;
            logic [WIDTHP-1:0]      p;
            logic [ACCW-1:0]        p_sx;
            logic [ACCW-1:0]        p_zx;

            assign ax   = {mul_sb.sgn & mul_a[l*WIDTHA+WIDTHA-1], mul_a[l*WIDTHA +: WIDTHA]};
            assign bx   = {mul_sb.sgn & mul_b[l*WIDTHB+WIDTHB-1], mul_b[l*WIDTHB +: WIDTHB]};
            assign p    = WIDTHP'(PFW'(ax) * PFW'(bx));
            assign p_sx = ACCW'(signed'(p));
            assign p_zx = ACCW'(p);
            assign prod_ext[l*ACCW +: ACCW] = mul_sb.sgn ? p_sx : p_zx;
        end
    endgenerate

    ctl_t                  m_ctl  [OS];
    logic [LANES*ACCW-1:0] m_prod [OS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < OS; i++) begin
                m_ctl[i]  <= '0;
                m_prod[i] <= '0;
            end
        end else if (!stall) begin
            m_ctl[0]  <= '{vld: mul_sb.vld, first: mul_sb.first, last: mul_sb.last};
            m_prod[0] <= prod_ext;
            for (int i = 1; i < OS; i++) begin
                m_ctl[i]  <= m_ctl[i-1];
                m_prod[i] <= m_prod[i-1];
            end
        end
    end

    logic                  a_vld;
    logic                  a_first;
    logic                  a_last;
    logic [LANES*ACCW-1:0] acc_q;
    logic [LANES*ACCW-1:0] acc_nxt;

    assign a_vld   = m_ctl[OS-1].vld;
    assign a_first = m_ctl[OS-1].first;
    assign a_last  = m_ctl[OS-1].last;

`ifdef MULT_ACC_SAT_EN
    localparam logic [ACCW-1:0] SMAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic [ACCW-1:0] SMIN = {1'b1, {(ACCW-1){1'b0}}};

    logic             m_sgn [OS];
    logic             a_sgn;
    logic [LANES-1:0] ovf;
    logic [LANES-1:0] sat_q;
    logic [LANES-1:0] sat_nxt;
    logic [LANES-1:0] sat_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < OS; i++) m_sgn[i] <= 1'b0;
        end else if (!stall) begin
            m_sgn[0] <= mul_sb.sgn;
            for (int i = 1; i < OS; i++) m_sgn[i] <= m_sgn[i-1];
        end
    end

    assign a_sgn   = m_sgn[OS-1];
    assign sat_nxt = (a_first ? '0 : sat_q) | ovf;
    assign out_sat = sat_out_q;
`else
    assign out_sat = '0;
`endif

    // first restarts the sum from zero; otherwise keep adding onto the running value
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_acc
            logic [ACCW-1:0] base;
            logic [ACCW-1:0] prod;

            assign base = a_first ? '0 : acc_q[l*ACCW +: ACCW];
            assign prod = m_prod[OS-1][l*ACCW +: ACCW];
`ifdef MULT_ACC_SAT_EN
            logic [ACCW:0] sum_u;
            logic          sovf;

            assign sum_u  = {1'b0, base} + {1'b0, prod};
            assign sovf   = (base[ACCW-1] == prod[ACCW-1]) && (sum_u[ACCW-1] != base[ACCW-1]);
            assign ovf[l] = a_sgn ? sovf : sum_u[ACCW];
            assign acc_nxt[l*ACCW +: ACCW] = !ovf[l] ? sum_u[ACCW-1:0] :
                                             a_sgn   ? (base[ACCW-1] ? SMIN : SMAX) : '1;
`else
            assign acc_nxt[l*ACCW +: ACCW] = base + prod;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            out_acc   <= '0;
            out_valid <= 1'b0;
`ifdef MULT_ACC_SAT_EN
            sat_q     <= '0;
            sat_out_q <= '0;
`endif
        end else if (!stall) begin
            out_valid <= a_vld && a_last;
            if (a_vld) begin
                acc_q <= acc_nxt;
`ifdef MULT_ACC_SAT_EN
                sat_q <= sat_nxt;
`endif
                if (a_last) begin
                    out_acc <= acc_nxt;
`ifdef MULT_ACC_SAT_EN
                    sat_out_q <= sat_nxt;
`endif
                end
            end
        end
    end

endmodule
